// File: rtl/axi4l_gpio_if.sv
// ============================================================================
//  Module   : axi4l_if
//  Purpose  : 32-bit AXI4-Lite bundle shared by masters and slaves.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface axi4l_if (
    input logic aclk,
    input logic aresetn
);
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  aclk, aresetn,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        input  aclk, aresetn,
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

`default_nettype wire

// File: rtl/axi4l_gpio.sv
// ============================================================================
//  Module   : axi4l_gpio
//  Purpose  : AXI4-Lite GPIO: output register, synchronised/debounced inputs,
//             edge-detect sticky status with level interrupt.
//             Define AXI4L_GPIO_DEBOUNCE_EN to build the input debouncers.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module axi4l_gpio #(
    parameter int NO         = 4,
    parameter int NI         = 8,
    parameter int DEB_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst_n,
    axi4l_if.slave        axi,
    input  logic [NI-1:0] gpio_i,
    output logic [NO-1:0] gpio_o,
    output logic          irq
);

    localparam logic [11:0] c_off_out     = 12'h000;
    localparam logic [11:0] c_off_in      = 12'h004;
    localparam logic [11:0] c_off_irq_en  = 12'h008;
    localparam logic [11:0] c_off_status  = 12'h00C;
    localparam logic [11:0] c_off_rise_en = 12'h010;
    localparam logic [11:0] c_off_fall_en = 12'h014;
    localparam logic [1:0]  c_resp_okay   = 2'b00;
    localparam logic [1:0]  c_resp_slverr = 2'b10;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic          r_live;
    logic [NO-1:0] r_out;
    logic [NI-1:0] r_irq_en;
    logic [NI-1:0] r_rise_en;
    logic [NI-1:0] r_fall_en;
    logic [NI-1:0] r_status;
    logic [NI-1:0] r_in;
    logic [NI-1:0] r_in_prev;
    logic [NI-1:0] r_sync1;
    logic [NI-1:0] r_sync2;
    logic          r_irq;
    logic          r_bvalid;
    logic [1:0]    r_bresp;
    logic          r_rvalid;
    logic [1:0]    r_rresp;
    logic [31:0]   r_rdata;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic        w_wr_hs;
    logic        w_wr_ok;
    logic        w_we_out;
    logic        w_we_irq_en;
    logic        w_we_status;
    logic        w_we_rise_en;
    logic        w_we_fall_en;
    logic [31:0] w_wmask;
    logic [31:0] w_wr_bits;

    // r_live keeps the readies low while reset is asserted.
    assign w_wr_hs     = r_live & axi.awvalid & axi.wvalid & ~r_bvalid;
    assign axi.awready = w_wr_hs;
    assign axi.wready  = w_wr_hs;
    assign axi.bvalid  = r_bvalid;
    assign axi.bresp   = r_bresp;

    assign w_wmask   = {{8{axi.wstrb[3]}}, {8{axi.wstrb[2]}},
                        {8{axi.wstrb[1]}}, {8{axi.wstrb[0]}}};
    assign w_wr_bits = axi.wdata & w_wmask;

    always_comb begin
        w_wr_ok      = 1'b0;
        w_we_out     = 1'b0;
        w_we_irq_en  = 1'b0;
        w_we_status  = 1'b0;
        w_we_rise_en = 1'b0;
        w_we_fall_en = 1'b0;
        case (axi.awaddr[11:0])
            c_off_out:     begin w_wr_ok = 1'b1; w_we_out     = w_wr_hs; end
            c_off_in:      begin w_wr_ok = 1'b1;                         end
            c_off_irq_en:  begin w_wr_ok = 1'b1; w_we_irq_en  = w_wr_hs; end
            c_off_status:  begin w_wr_ok = 1'b1; w_we_status  = w_wr_hs; end
            c_off_rise_en: begin w_wr_ok = 1'b1; w_we_rise_en = w_wr_hs; end
            c_off_fall_en: begin w_wr_ok = 1'b1; w_we_fall_en = w_wr_hs; end
            default:       begin w_wr_ok = 1'b0;                         end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live   <= 1'b0;
            r_bvalid <= 1'b0;
            r_bresp  <= c_resp_okay;
        end else begin
            r_live <= 1'b1;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? c_resp_okay : c_resp_slverr;
            end else if (axi.bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic        w_ar_rdy;
    logic        w_rd_hs;
    logic        w_rd_ok;
    logic [31:0] w_rd_data;

    // A pending response being accepted this cycle frees the slot, so
    // reads stream one per cycle while rready is held.
    assign w_ar_rdy    = r_live & (~r_rvalid | axi.rready);
    assign w_rd_hs     = w_ar_rdy & axi.arvalid;
    assign axi.arready = w_ar_rdy;
    assign axi.rvalid  = r_rvalid;
    assign axi.rresp   = r_rresp;
    assign axi.rdata   = r_rdata;

    always_comb begin
        w_rd_data = '0;
        w_rd_ok   = 1'b1;
        case (axi.araddr[11:0])
            c_off_out:     w_rd_data[NO-1:0] = r_out;
            c_off_in:      w_rd_data[NI-1:0] = r_in;
            c_off_irq_en:  w_rd_data[NI-1:0] = r_irq_en;
            c_off_status:  w_rd_data[NI-1:0] = r_status;
            c_off_rise_en: w_rd_data[NI-1:0] = r_rise_en;
            c_off_fall_en: w_rd_data[NI-1:0] = r_fall_en;
            default:       w_rd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rresp  <= c_resp_okay;
            r_rdata  <= '0;
        end else if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_ok ? c_resp_okay : c_resp_slverr;
            r_rdata  <= w_rd_data;
        end else if (axi.rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Input path: synchroniser, optional debouncer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_i;
            r_sync2 <= r_sync1;
        end
    end

`ifdef AXI4L_GPIO_DEBOUNCE_EN
    localparam int             c_cnt_w    = $clog2(DEB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt [NI];

    // Counting runs only while the synchronised bit disagrees with IN;
    // any return to agreement restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in <= '0;
            for (int i = 0; i < NI; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (r_sync2[i] == r_in[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_cnt_last) begin
                    r_cnt[i] <= '0;
                    r_in[i]  <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in <= '0;
        end else begin
            r_in <= r_sync2;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control registers, edge detect, status and interrupt
    // ------------------------------------------------------------------
    logic [NI-1:0] w_set;
    logic [NI-1:0] w_clr;

    assign w_set = (r_in & ~r_in_prev & r_rise_en) | (~r_in & r_in_prev & r_fall_en);
    assign w_clr = w_we_status ? w_wr_bits[NI-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_irq_en  <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_in_prev <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_we_out) begin
                r_out <= (r_out & ~w_wmask[NO-1:0]) | w_wr_bits[NO-1:0];
            end
            if (w_we_irq_en) begin
                r_irq_en <= (r_irq_en & ~w_wmask[NI-1:0]) | w_wr_bits[NI-1:0];
            end
            if (w_we_rise_en) begin
                r_rise_en <= (r_rise_en & ~w_wmask[NI-1:0]) | w_wr_bits[NI-1:0];
            end
            if (w_we_fall_en) begin
                r_fall_en <= (r_fall_en & ~w_wmask[NI-1:0]) | w_wr_bits[NI-1:0];
            end
            // New edges take priority over a coincident clear.
            r_status  <= (r_status & ~w_clr) | w_set;
            r_in_prev <= r_in;
            r_irq     <= |(r_status & r_irq_en);
        end
    end

    assign gpio_o = r_out;
    assign irq    = r_irq;

    logic w_unused;
    assign w_unused = ^{axi.aclk, axi.aresetn, axi.awaddr[31:12], axi.araddr[31:12],
                        axi.awprot, axi.arprot, w_wmask, w_wr_bits};

endmodule

`default_nettype wire

// File: tb/tb_axi4l_gpio.sv
// ============================================================================
//  Module   : tb_axi4l_gpio
//  Purpose  : Directed, table-driven bench for axi4l_gpio (NO=4, NI=8, DEB=4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi4l_gpio;

    localparam int c_no  = 4;
    localparam int c_ni  = 8;
    localparam int c_deb = 4;
`ifdef AXI4L_GPIO_DEBOUNCE_EN
    localparam int c_lat = 2 + c_deb;
`else
    localparam int c_lat = 3;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [c_ni-1:0] gpio_i;
    logic [c_no-1:0] gpio_o;
    logic            irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi4l_if axi_bus (.aclk(clk), .aresetn(rst_n));

    axi4l_gpio #(.NO(c_no), .NI(c_ni), .DEB_CYCLES(c_deb)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .axi    (axi_bus.slave),
        .gpio_i (gpio_i),
        .gpio_o (gpio_o),
        .irq    (irq)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic [3:0]  exp_gpio;
    } vec_t;

    localparam int c_nv = 26;
    vec_t vecs [c_nv];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: handshake timeout got none expected ready", name);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [c_no-1:0] hs_gpio, output logic hs_irq);
        bit done = 0;
        axi_bus.awaddr  = addr;
        axi_bus.awprot  = 3'b000;
        axi_bus.wdata   = data;
        axi_bus.wstrb   = strb;
        axi_bus.awvalid = 1'b1;
        axi_bus.wvalid  = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (axi_bus.awready && axi_bus.wready) done = 1;
            @(posedge clk);
            #1;
        end
        axi_bus.awvalid = 1'b0;
        axi_bus.wvalid  = 1'b0;
        if (!done) timeout("aw_w");
        hs_gpio = gpio_o;
        hs_irq  = irq;
        chk("bvalid_rise", {31'd0, axi_bus.bvalid}, 32'd1);
        resp = axi_bus.bresp;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit done = 0;
        axi_bus.araddr  = addr;
        axi_bus.arprot  = 3'b000;
        axi_bus.arvalid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (axi_bus.arready) done = 1;
            @(posedge clk);
            #1;
        end
        axi_bus.arvalid = 1'b0;
        if (!done) timeout("ar");
        chk("rvalid_rise", {31'd0, axi_bus.rvalid}, 32'd1);
        data = axi_bus.rdata;
        resp = axi_bus.rresp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0]     rd;
        logic [1:0]      rsp;
        logic [c_no-1:0] g;
        logic            iq;
        int              first;
        bit              seen;

        //            wr  addr      data          strb   rdata        resp   gpio
        vecs[0]  = '{1'b0, 32'h000, 32'h0,        4'h0, 32'h0,        2'b00, 4'h0};
        vecs[1]  = '{1'b0, 32'h004, 32'h0,        4'h0, 32'h0,        2'b00, 4'h0};
        vecs[2]  = '{1'b0, 32'h008, 32'h0,        4'h0, 32'h0,        2'b00, 4'h0};
        vecs[3]  = '{1'b0, 32'h00C, 32'h0,        4'h0, 32'h0,        2'b00, 4'h0};
        vecs[4]  = '{1'b0, 32'h010, 32'h0,        4'h0, 32'h0,        2'b00, 4'h0};
        vecs[5]  = '{1'b0, 32'h014, 32'h0,        4'h0, 32'h0,        2'b00, 4'h0};
        vecs[6]  = '{1'b0, 32'h018, 32'h0,        4'h0, 32'h0,        2'b10, 4'h0};
        vecs[7]  = '{1'b1, 32'h018, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10, 4'h0};
        vecs[8]  = '{1'b0, 32'h000, 32'h0,        4'h0, 32'h0,        2'b00, 4'h0};
        vecs[9]  = '{1'b0, 32'h010, 32'h0,        4'h0, 32'h0,        2'b00, 4'h0};
        vecs[10] = '{1'b1, 32'h000, 32'h0000000F, 4'h1, 32'h0,        2'b00, 4'hF};
        vecs[11] = '{1'b1, 32'h000, 32'h0,        4'h0, 32'h0,        2'b00, 4'hF};
        vecs[12] = '{1'b0, 32'h000, 32'h0,        4'h0, 32'h0000000F, 2'b00, 4'hF};
        vecs[13] = '{1'b1, 32'h008, 32'hFFFFFF5A, 4'h1, 32'h0,        2'b00, 4'hF};
        vecs[14] = '{1'b1, 32'h008, 32'h000000FF, 4'h2, 32'h0,        2'b00, 4'hF};
        vecs[15] = '{1'b0, 32'h008, 32'h0,        4'h0, 32'h0000005A, 2'b00, 4'hF};
        vecs[16] = '{1'b1, 32'h010, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00, 4'hF};
        vecs[17] = '{1'b0, 32'h010, 32'h0,        4'h0, 32'h000000FF, 2'b00, 4'hF};
        vecs[18] = '{1'b1, 32'h014, 32'h00000103, 4'h3, 32'h0,        2'b00, 4'hF};
        vecs[19] = '{1'b0, 32'h014, 32'h0,        4'h0, 32'h00000003, 2'b00, 4'hF};
        vecs[20] = '{1'b1, 32'h00C, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00, 4'hF};
        vecs[21] = '{1'b0, 32'h00C, 32'h0,        4'h0, 32'h0,        2'b00, 4'hF};
        vecs[22] = '{1'b0, 32'h001, 32'h0,        4'h0, 32'h0,        2'b10, 4'hF};
        vecs[23] = '{1'b1, 32'h000, 32'hFFFFFFF5, 4'hF, 32'h0,        2'b00, 4'h5};
        vecs[24] = '{1'b0, 32'h000, 32'h0,        4'h0, 32'h00000005, 2'b00, 4'h5};
        vecs[25] = '{1'b0, 32'h004, 32'h0,        4'h0, 32'h0,        2'b00, 4'h5};

        rst_n           = 1'b0;
        gpio_i          = '0;
        axi_bus.awaddr  = '0;
        axi_bus.awprot  = '0;
        axi_bus.awvalid = 1'b0;
        axi_bus.wdata   = '0;
        axi_bus.wstrb   = '0;
        axi_bus.wvalid  = 1'b0;
        axi_bus.bready  = 1'b1;
        axi_bus.araddr  = '0;
        axi_bus.arprot  = '0;
        axi_bus.arvalid = 1'b0;
        axi_bus.rready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, gpio_o, irq, axi_bus.bvalid},  32'd0);
        chk("reset_handshake", {28'd0, axi_bus.awready, axi_bus.wready,
                                axi_bus.arready, axi_bus.rvalid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < c_nv; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp, g, iq);
                chk($sformatf("v%0d_bresp", i), {30'd0, rsp}, {30'd0, vecs[i].exp_resp});
                chk($sformatf("v%0d_gpio", i), {28'd0, g}, {28'd0, vecs[i].exp_gpio});
            end else begin
                axi_read(vecs[i].addr, rd, rsp);
                chk($sformatf("v%0d_rresp", i), {30'd0, rsp}, {30'd0, vecs[i].exp_resp});
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end

        axi_write(32'h008, 32'h1,  4'h1, rsp, g, iq);
        axi_write(32'h010, 32'h1,  4'h1, rsp, g, iq);
        axi_write(32'h014, 32'h0,  4'h1, rsp, g, iq);
        axi_write(32'h00C, 32'hFF, 4'h1, rsp, g, iq);

`ifdef AXI4L_GPIO_DEBOUNCE_EN
        // Three synchronised cycles high is one short of acceptance.
        gpio_i[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        gpio_i[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (irq) seen = 1;
        end
        chk("glitch_irq", {31'd0, seen}, 32'd0);
        axi_read(32'h004, rd, rsp);
        chk("glitch_in", rd, 32'd0);
`endif

        gpio_i[0] = 1'b1;
        first = 0;
        for (int k = 1; k <= 40 && first == 0; k++) begin
            @(posedge clk);
            #1;
            if (irq) first = k;
        end
        chk("rise_irq_latency", first, c_lat + 2);
        axi_read(32'h004, rd, rsp);
        chk("rise_in", rd, 32'd1);
        axi_read(32'h00C, rd, rsp);
        chk("rise_status", rd, 32'd1);

        axi_write(32'h00C, 32'h1, 4'h1, rsp, g, iq);
        chk("w1c_irq_at_hs", {31'd0, iq}, 32'd1);
        chk("w1c_irq_after", {31'd0, irq}, 32'd0);
        axi_read(32'h00C, rd, rsp);
        chk("w1c_status", rd, 32'd0);

        axi_write(32'h014, 32'h1, 4'h1, rsp, g, iq);
        gpio_i[0] = 1'b0;
        repeat (c_lat) @(posedge clk);
        #1;
        // Clear lands on the same edge the falling edge sets STATUS[0].
        axi_write(32'h00C, 32'h1, 4'h1, rsp, g, iq);
        chk("setwins_irq", {31'd0, irq}, 32'd1);
        axi_read(32'h00C, rd, rsp);
        chk("setwins_status", rd, 32'd1);

`ifndef AXI4L_GPIO_DEBOUNCE_EN
        axi_write(32'h00C, 32'h1, 4'h1, rsp, g, iq);
        axi_write(32'h010, 32'h2, 4'h1, rsp, g, iq);
        axi_write(32'h008, 32'h2, 4'h1, rsp, g, iq);
        gpio_i[1] = 1'b1;
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) gpio_i[1] = 1'b0;
            if (irq) first = k;
        end
        chk("pulse_irq_latency", first, c_lat + 2);
        axi_read(32'h00C, rd, rsp);
        chk("pulse_status", rd, 32'd2);
        axi_read(32'h004, rd, rsp);
        chk("pulse_in_gone", rd, 32'd0);
`endif

        axi_bus.bready  = 1'b0;
        axi_bus.rready  = 1'b0;
        axi_bus.awaddr  = 32'h000;
        axi_bus.wdata   = 32'h0000000A;
        axi_bus.wstrb   = 4'h1;
        axi_bus.awvalid = 1'b1;
        axi_bus.wvalid  = 1'b1;
        axi_bus.araddr  = 32'h000;
        axi_bus.arvalid = 1'b1;
        @(posedge clk);
        #1;
        axi_bus.awvalid = 1'b0;
        axi_bus.wvalid  = 1'b0;
        axi_bus.arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_flags", {28'd0, axi_bus.bvalid, axi_bus.rvalid,
                               axi_bus.arready, axi_bus.awready}, 32'hC);
            chk("hold_rdata", axi_bus.rdata, 32'd5);
            @(posedge clk);
            #1;
        end
        chk("hold_gpio", {28'd0, gpio_o}, 32'hA);

        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valids", {30'd0, axi_bus.bvalid, axi_bus.rvalid}, 32'd0);
        chk("rst_gpio", {28'd0, gpio_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n          = 1'b1;
        axi_bus.bready = 1'b1;
        axi_bus.rready = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (axi_bus.bvalid || axi_bus.rvalid) seen = 1;
        end
        chk("no_stale_valid", {31'd0, seen}, 32'd0);
        axi_read(32'h000, rd, rsp);
        chk("post_rst_out", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
